// File: rtl/kernel_launcher.sv
// kernel_launcher: host-side launch sequencer for the GPU top level.
// Queues kernel launch commands (thread counts) in a small FIFO. For each
// command it holds the GPU in reset, writes the device control register,
// holds start until done (or timeout), then returns a completion record.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   cmd_valid/ready/thread_count  launch command push interface
//   rsp_valid/ready/thread_count/cycles/timeout  completion record
//   gpu_reset, gpu_start, gpu_done                GPU handshake
//   device_control_write_enable/data              control register write
//   busy, queue_count          status
module kernel_launcher #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int CYCLE_BITS     = 16,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int RESET_CYCLES   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_thread_count,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [7:0]                    rsp_thread_count,
  output logic [CYCLE_BITS-1:0]         rsp_cycles,
  output logic                          rsp_timeout,
  output logic                          gpu_reset,
  output logic                          gpu_start,
  input  logic                          gpu_done,
  output logic                          device_control_write_enable,
  output logic [7:0]                    device_control_data,
  output logic                          busy,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [RW-1:0]         RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [CYCLE_BITS-1:0] TO_LIMIT = CYCLE_BITS'(TIMEOUT_CYCLES);
  localparam logic [PW:0]           DEPTH    = (PW + 1)'(QUEUE_DEPTH);

  typedef enum logic [2:0] {S_RESET, S_IDLE, S_CONFIG, S_RUN, S_RESP} state_t;

  typedef struct packed {
    logic [7:0]            thread_count;
    logic [CYCLE_BITS-1:0] cycles;
    logic                  timeout;
  } rsp_t;

  // ---------------- command FIFO ----------------
  logic [7:0]    mem [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count_n;
  logic          push, pop;
  logic [7:0]    head;

  assign cmd_ready = (queue_count != DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  always_comb begin
    count_n = queue_count;
    case ({push, pop})
      2'b10:   count_n = queue_count + 1'b1;
      2'b01:   count_n = queue_count - 1'b1;
      default: count_n = queue_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_thread_count;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      queue_count <= count_n;
    end
  end

  // ---------------- launch FSM ----------------
  state_t                state, state_n;
  logic [RW-1:0]         rst_cnt, rst_cnt_n;
  logic [CYCLE_BITS-1:0] run_cnt, run_cnt_n;
  logic [7:0]            cur_tc, cur_tc_n;
  logic [7:0]            dcd_n;
  rsp_t                  rsp_q, rsp_n;
  logic                  rsp_valid_n;

  always_comb begin
    state_n     = state;
    rst_cnt_n   = rst_cnt;
    run_cnt_n   = run_cnt;
    cur_tc_n    = cur_tc;
    dcd_n       = device_control_data;
    rsp_n       = rsp_q;
    rsp_valid_n = rsp_valid;
    pop         = 1'b0;
    case (state)
      S_RESET: begin
        if (rst_cnt == RST_LAST) state_n = S_IDLE;
        else                     rst_cnt_n = rst_cnt + 1'b1;
      end
      S_IDLE: begin
        if (queue_count != '0) begin
          pop      = 1'b1;
          cur_tc_n = head;
          if (head == 8'd0) begin
            // Empty launch: complete immediately, GPU never leaves reset.
            state_n     = S_RESP;
            rsp_valid_n = 1'b1;
            rsp_n       = '{thread_count: 8'd0, cycles: '0, timeout: 1'b0};
          end else begin
            state_n = S_CONFIG;
            dcd_n   = head;
          end
        end
      end
      S_CONFIG: begin
        run_cnt_n = '0;
        state_n   = S_RUN;
      end
      S_RUN: begin
        // Done wins over a coincident timeout.
        if (gpu_done) begin
          state_n     = S_RESP;
          rsp_valid_n = 1'b1;
          rsp_n       = '{thread_count: cur_tc, cycles: run_cnt, timeout: 1'b0};
        end else if ((TIMEOUT_CYCLES != 0) && (run_cnt == TO_LIMIT)) begin
          state_n     = S_RESP;
          rsp_valid_n = 1'b1;
          rsp_n       = '{thread_count: cur_tc, cycles: TO_LIMIT, timeout: 1'b1};
        end else if (run_cnt != '1) begin
          run_cnt_n = run_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          rst_cnt_n   = '0;
          state_n     = S_RESET;
        end
      end
      default: state_n = S_RESET;
    endcase
  end

  // GPU-facing outputs are decoded from the next state so they line up
  // with the state they belong to while still coming straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                       <= S_RESET;
      rst_cnt                     <= '0;
      run_cnt                     <= '0;
      cur_tc                      <= '0;
      rsp_q                       <= '0;
      rsp_valid                   <= 1'b0;
      gpu_reset                   <= 1'b1;
      gpu_start                   <= 1'b0;
      device_control_write_enable <= 1'b0;
      device_control_data         <= '0;
      busy                        <= 1'b0;
    end else begin
      state                       <= state_n;
      rst_cnt                     <= rst_cnt_n;
      run_cnt                     <= run_cnt_n;
      cur_tc                      <= cur_tc_n;
      rsp_q                       <= rsp_n;
      rsp_valid                   <= rsp_valid_n;
      gpu_reset                   <= !(state_n == S_CONFIG || state_n == S_RUN);
      gpu_start                   <= (state_n == S_RUN);
      device_control_write_enable <= (state_n == S_CONFIG);
      device_control_data         <= dcd_n;
      busy                        <= (state_n != S_IDLE) || (count_n != '0);
    end
  end

  assign rsp_thread_count = rsp_q.thread_count;
  assign rsp_cycles       = rsp_q.cycles;
  assign rsp_timeout      = rsp_q.timeout;

endmodule

// File: tb/tb_kernel_launcher.sv
// Self-checking bench for kernel_launcher: expected completion records are
// queued as commands are issued; a monitor pops and compares on every
// response handshake. A simple GPU model raises done a programmable number
// of cycles after start.
module tb_kernel_launcher;
  localparam int CB = 16;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_thread_count = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [7:0]    rsp_thread_count;
  logic [CB-1:0] rsp_cycles;
  logic          rsp_timeout;
  logic          gpu_reset, gpu_start, gpu_done;
  logic          device_control_write_enable;
  logic [7:0]    device_control_data;
  logic          busy;
  logic [2:0]    queue_count;

  kernel_launcher #(
    .QUEUE_DEPTH(4), .CYCLE_BITS(CB), .TIMEOUT_CYCLES(10), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_thread_count(cmd_thread_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_thread_count(rsp_thread_count),
    .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout),
    .gpu_reset(gpu_reset), .gpu_start(gpu_start), .gpu_done(gpu_done),
    .device_control_write_enable(device_control_write_enable),
    .device_control_data(device_control_data),
    .busy(busy), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  // GPU model: done fires when start has been high for done_delay cycles.
  int done_delay = 1000;
  int age = 0;
  always @(posedge clk) begin
    if (!gpu_start) age <= 0;
    else            age <= age + 1;
  end
  assign gpu_done = gpu_start && (age == done_delay);

  typedef struct packed {
    logic [7:0]    tc;
    logic [CB-1:0] cyc;
    logic          to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rst_run = 0;
  int   n_we = 0;
  int   n_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got thread_count %0d expected no response", rsp_thread_count);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_thread_count", rsp_thread_count, mon_e.tc);
        check("rsp_cycles", rsp_cycles, mon_e.cyc);
        check("rsp_timeout", rsp_timeout, mon_e.to);
      end
    end
  end

  // Reset gap before each control write, strobe and start-cycle counts.
  always @(negedge clk) begin
    if (gpu_start) n_start++;
    if (gpu_reset) rst_run++;
    else begin
      if (device_control_write_enable) begin
        n_we++;
        n_checks++;
        if (rst_run < RC) begin
          n_fail++;
          $display("FAIL reset_gap: got %0d cycles expected >= %0d", rst_run, RC);
        end
      end
      rst_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [7:0] tc, input logic [CB-1:0] cyc, input logic to);
    exp_t e;
    int   w;
    e.tc = tc; e.cyc = cyc; e.to = to;
    cmd_valid = 1'b1;
    cmd_thread_count = tc;
    w = 0;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    if (w == 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_ready: got cmd_ready 0 expected 1 within 200 cycles");
    end
    sb.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int w;
    w = 0;
    while (sb.size() != 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic wait_rsp(input int budget);
    int w;
    w = 0;
    @(negedge clk);
    while (!rsp_valid && w < budget) begin
      @(negedge clk);
      w++;
    end
    check("rsp_valid_seen", rsp_valid, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n_we0, n_st0, stale;
    logic last_start;

    // Reset state
    @(negedge clk);
    check("rst_queue_count", queue_count, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_gpu_reset", gpu_reset, 1);
    check("rst_gpu_start", gpu_start, 0);
    check("rst_dcwe", device_control_write_enable, 0);
    check("rst_dcd", device_control_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_tc", rsp_thread_count, 0);
    check("rst_rsp_cycles", rsp_cycles, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    #2 reset = 1'b1;
    idle(5);

    // 1: single launch, latency and record
    done_delay = 5;
    push(8'd8, 16'd5, 1'b0);
    @(negedge clk);
    check("t1_q_after_push", queue_count, 1);
    check("t1_no_we_yet", device_control_write_enable, 0);
    @(negedge clk);
    check("t1_config_we", device_control_write_enable, 1);
    check("t1_config_data", device_control_data, 8);
    check("t1_config_reset", gpu_reset, 0);
    check("t1_config_start", gpu_start, 0);
    @(negedge clk);
    check("t1_run_start", gpu_start, 1);
    check("t1_run_we", device_control_write_enable, 0);
    check("t1_busy", busy, 1);
    drain(50);
    idle(4);
    check("t1_idle_busy", busy, 0);

    // 2: fill the queue while the first response is stalled
    done_delay = 2;
    rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i), 16'd2, 1'b0);
    check("t2_full_ready", cmd_ready, 0);
    check("t2_full_count", queue_count, 4);
    wait_rsp(50);
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", rsp_valid, 1);
      check("t2_hold_tc", rsp_thread_count, 1);
      check("t2_hold_cycles", rsp_cycles, 2);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain(300);
    idle(4);

    // 3: zero thread count never starts the GPU
    n_we0 = n_we;
    n_st0 = n_start;
    push(8'd0, 16'd0, 1'b0);
    drain(50);
    idle(4);
    check("t3_no_we", n_we, n_we0);
    check("t3_no_start", n_start, n_st0);

    // 4a: timeout
    done_delay = 1000;
    push(8'd7, 16'd10, 1'b1);
    last_start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
      last_start = gpu_start;
    end
    check("t4_to_valid", rsp_valid, 1);
    check("t4_start_before", last_start, 1);
    check("t4_start_drop", gpu_start, 0);
    drain(20);
    idle(4);
    // 4b: done coincident with timeout counts as done
    done_delay = 10;
    push(8'd9, 16'd10, 1'b0);
    drain(60);
    idle(4);

    // 5: reset during RUN with two commands queued
    done_delay = 1000;
    push(8'd20, 16'd0, 1'b0);
    push(8'd21, 16'd0, 1'b0);
    push(8'd22, 16'd0, 1'b0);
    check("t5_pre_count", queue_count, 2);
    check("t5_pre_start", gpu_start, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_start", gpu_start, 0);
    check("t5_gpu_reset", gpu_reset, 1);
    check("t5_count", queue_count, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stale = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    check("t5_stale_rsp", stale, 0);
    check("t5_post_count", queue_count, 0);
    check("t5_post_busy", busy, 0);

    // 6: push and pop in the same cycle at depth-1
    done_delay = 1;
    rsp_ready = 1'b0;
    push(8'd10, 16'd1, 1'b0);
    push(8'd11, 16'd1, 1'b0);
    push(8'd12, 16'd1, 1'b0);
    push(8'd13, 16'd1, 1'b0);
    wait_rsp(50);
    check("t6_count3", queue_count, 3);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    idle(3);
    cmd_valid = 1'b1;
    cmd_thread_count = 8'd14;
    sb.push_back('{tc: 8'd14, cyc: 16'd1, to: 1'b0});
    @(negedge clk);
    check("t6_count_pop_cycle", queue_count, 3);
    tick();
    cmd_valid = 1'b0;
    check("t6_count_after", queue_count, 3);
    drain(300);
    idle(6);
    check("t6_final_count", queue_count, 0);
    check("t6_final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
